// File: rtl/swap_xchg_pkg.sv
// ============================================================================
// Module : swap_xchg_pkg
// Brief  : Shared FSM state encoding, op encodings and default widths for
//          the swap/exchange register file.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package swap_xchg_pkg;

  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_DATA_WIDTH = 8;

  localparam logic OP_SWAP = 1'b0;
  localparam logic OP_COPY = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR_A = 3'd2,
    ST_WR_B = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/swap_xchg_mem.sv
// ============================================================================
// Module : swap_xchg_mem
// Brief  : Storage array, one synchronous write port, three async read ports.
//          SWAP_XCHG_CLEAR_EN: when defined, reset clears every word.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module swap_xchg_mem
  import swap_xchg_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  output logic [DATA_WIDTH-1:0] rdata_b_o,
  input  logic [ADDR_WIDTH-1:0] raddr_r_i,
  output logic [DATA_WIDTH-1:0] rdata_r_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

`ifdef SWAP_XCHG_CLEAR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end
`else
  // Storage keeps its contents across reset in this build.
  logic w_unused_reset;
  assign w_unused_reset = reset;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end
`endif

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];
  assign rdata_r_o = mem_q[raddr_r_i];

endmodule

`default_nettype wire

// File: rtl/swap_xchg_reg_file.sv
// ============================================================================
// Module : swap_xchg_reg_file
// Brief  : Register file with a multi-cycle swap (A<->B) / copy (A->B) engine.
//          SWAP_XCHG_CLEAR_EN: when defined, reset clears storage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module swap_xchg_reg_file
  import swap_xchg_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] address_w,
  input  logic [DATA_WIDTH-1:0] data_w,
  input  logic [ADDR_WIDTH-1:0] address_r,
  output logic [DATA_WIDTH-1:0] data_r,
  input  logic [ADDR_WIDTH-1:0] address_A,
  input  logic [ADDR_WIDTH-1:0] address_B,
  input  logic                  op,
  input  logic                  start,
  output logic                  ready,
  output logic                  done
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] a_q, b_q;
  logic                  op_q;
  logic [DATA_WIDTH-1:0] tmp_a_q, tmp_b_q;
  logic                  ready_q, done_q;

  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_data;
  logic [DATA_WIDTH-1:0] w_rd_a, w_rd_b;

  swap_xchg_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk       (clk),
    .reset     (reset),
    .we_i      (w_mem_we),
    .waddr_i   (w_mem_addr),
    .wdata_i   (w_mem_data),
    .raddr_a_i (a_q),
    .rdata_a_o (w_rd_a),
    .raddr_b_i (b_q),
    .rdata_b_o (w_rd_b),
    .raddr_r_i (address_r),
    .rdata_r_o (data_r)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RD;
      ST_RD:   state_d = (op_q == OP_COPY) ? ST_WR_B : ST_WR_A;
      ST_WR_A: state_d = ST_WR_B;
      ST_WR_B: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset suppresses every write so an aborted operation commits nothing more.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = address_w;
    w_mem_data = data_w;
    if (!reset) begin
      case (state_q)
        ST_IDLE: w_mem_we = we & ready_q;
        ST_WR_A: begin
          w_mem_we   = 1'b1;
          w_mem_addr = a_q;
          w_mem_data = tmp_b_q;
        end
        ST_WR_B: begin
          w_mem_we   = 1'b1;
          w_mem_addr = b_q;
          w_mem_data = tmp_a_q;
        end
        default: w_mem_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_SWAP;
      tmp_a_q <= '0;
      tmp_b_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      if (state_q == ST_IDLE && start) begin
        a_q  <= address_A;
        b_q  <= address_B;
        op_q <= op;
      end
      if (state_q == ST_RD) begin
        tmp_a_q <= w_rd_a;
        tmp_b_q <= w_rd_b;
      end
    end
  end

  assign ready = ready_q;
  assign done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_swap_xchg_reg_file.sv
// ============================================================================
// Module : tb_swap_xchg_reg_file
// Brief  : Self-checking bench: table-driven fill/read plus swap, copy,
//          blocking, same-edge write, A==B and mid-operation reset sequences.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_swap_xchg_reg_file;

  logic       clk = 1'b0;
  logic       reset;
  logic       we;
  logic [6:0] address_w;
  logic [7:0] data_w;
  logic [6:0] address_r;
  logic [7:0] data_r;
  logic [6:0] address_A;
  logic [6:0] address_B;
  logic       op;
  logic       start;
  logic       ready;
  logic       done;

  int checks   = 0;
  int failures = 0;

  swap_xchg_reg_file #(
    .ADDR_WIDTH (7),
    .DATA_WIDTH (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .address_w (address_w),
    .data_w    (data_w),
    .address_r (address_r),
    .data_r    (data_r),
    .address_A (address_A),
    .address_B (address_B),
    .op        (op),
    .start     (start),
    .ready     (ready),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [6:0] aw;
    logic [7:0] dw;
    logic [6:0] ar;
    logic [7:0] exp_r;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic rd_chk(input string name, input logic [6:0] a, input logic [7:0] e);
    address_r = a;
    #1;
    chk(name, {24'd0, data_r}, {24'd0, e});
  endtask

  // Launch one operation and measure done timing, done count and busy length.
  task automatic do_op(input string name, input logic o, input logic [6:0] a,
                       input logic [6:0] b, input int exp_cyc);
    int cyc, done_cyc, ndone, low;
    @(negedge clk);
    start = 1'b1; op = o; address_A = a; address_B = b;
    @(posedge clk); #1;
    start = 1'b0; address_A = a ^ 7'h55; address_B = b ^ 7'h2A; op = ~o;
    cyc = 1; done_cyc = 0; ndone = 0; low = 0;
    while (cyc <= 12) begin
      if (!ready) low++;
      if (done) begin
        ndone++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (ready) break;
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, "_done_cycle"}, done_cyc, exp_cyc);
    chk({name, "_done_count"}, ndone, 1);
    chk({name, "_busy_cycles"}, low, exp_cyc);
    chk({name, "_ready_back"}, {31'd0, ready}, 1);
  endtask

  initial begin
    int ndone, low;
    reset = 1'b1; we = 1'b0; address_w = '0; data_w = '0; address_r = '0;
    address_A = '0; address_B = '0; op = 1'b0; start = 1'b0;

    for (int i = 0; i < 10; i++) begin
      vecs[i] = '{we: 1'b1, aw: 7'(20 + i), dw: 8'(20 + i), ar: 7'(20 + i), exp_r: 8'(20 + i)};
    end
    for (int i = 0; i < 10; i++) begin
      vecs[10 + i] = '{we: 1'b0, aw: 7'd0, dw: 8'hFF, ar: 7'(29 - i), exp_r: 8'(29 - i)};
    end

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {31'd0, ready}, 1);
    chk("reset_done", {31'd0, done}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", {31'd0, ready}, 1);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      we = vecs[i].we; address_w = vecs[i].aw; data_w = vecs[i].dw; address_r = vecs[i].ar;
      @(posedge clk); #1;
      chk($sformatf("table_rd_%0d", i), {24'd0, data_r}, {24'd0, vecs[i].exp_r});
    end
    @(negedge clk);
    we = 1'b0;

    do_op("swap", 1'b0, 7'd22, 7'd28, 4);
    rd_chk("swap_m22", 7'd22, 8'd28);
    rd_chk("swap_m28", 7'd28, 8'd22);

    do_op("copy", 1'b1, 7'd21, 7'd25, 3);
    rd_chk("copy_m25", 7'd25, 8'd21);
    rd_chk("copy_m21", 7'd21, 8'd21);

    // Start held 3 cycles and external writes while busy are both ignored.
    @(negedge clk);
    start = 1'b1; op = 1'b0; address_A = 7'd22; address_B = 7'd28;
    @(posedge clk); #1;
    ndone = 0; low = 0;
    for (int c = 1; c <= 12; c++) begin
      if (done) ndone++;
      if (!ready) low++;
      @(negedge clk);
      if (c == 1) begin we = 1'b1; address_w = 7'd24; data_w = 8'hAA; end
      if (c == 3) begin start = 1'b0; we = 1'b0; end
      @(posedge clk); #1;
    end
    chk("block_done_count", ndone, 1);
    chk("block_busy_cycles", low, 4);
    rd_chk("block_m24", 7'd24, 8'd24);
    rd_chk("block_m22", 7'd22, 8'd22);
    rd_chk("block_m28", 7'd28, 8'd28);

    // External write and start accepted on the same edge.
    @(negedge clk);
    we = 1'b1; address_w = 7'd26; data_w = 8'h5A;
    start = 1'b1; op = 1'b1; address_A = 7'd26; address_B = 7'd27;
    @(posedge clk); #1;
    we = 1'b0; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("same_edge_ready", {31'd0, ready}, 1);
    rd_chk("same_edge_m27", 7'd27, 8'h5A);
    rd_chk("same_edge_m26", 7'd26, 8'h5A);

    do_op("aeqb", 1'b0, 7'd23, 7'd23, 4);
    rd_chk("aeqb_m23", 7'd23, 8'd23);

    // Reset asserted on the edge that would commit the WR_B write.
    @(negedge clk);
    start = 1'b1; op = 1'b0; address_A = 7'd22; address_B = 7'd28;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready", {31'd0, ready}, 1);
    chk("rst_mid_done", {31'd0, done}, 0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("rst_mid_no_done", ndone, 0);
`ifdef SWAP_XCHG_CLEAR_EN
    rd_chk("rst_mid_m22", 7'd22, 8'd0);
    rd_chk("rst_mid_m28", 7'd28, 8'd0);
`else
    rd_chk("rst_mid_m22", 7'd22, 8'd28);
    rd_chk("rst_mid_m28", 7'd28, 8'd28);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/swap_xchg_reg_file.md
SWAP_XCHG_REG_FILE -- requirements
Module: swap_xchg_reg_file

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7, meaning the address bits; depth = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning the word width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port we, input, 1 bit: external write enable.
REQ-006 SHALL have port address_w, input, ADDR_WIDTH: external write address.
REQ-007 SHALL have port data_w, input, DATA_WIDTH: external write data.
REQ-008 SHALL have port address_r, input, ADDR_WIDTH: read address.
REQ-009 SHALL have port data_r, output, DATA_WIDTH: read data.
REQ-010 SHALL have port address_A, input, ADDR_WIDTH: operand address A.
REQ-011 SHALL have port address_B, input, ADDR_WIDTH: operand address B.
REQ-012 SHALL have port op, input, 1 bit: 0 = swap A<->B; 1 = copy A->B.
REQ-013 SHALL have port start, input, 1 bit: operation request.
REQ-014 SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-016 data_r SHALL be combinational, mem[address_r], with no cycle latency.
REQ-017 An external write SHALL occur on the edge where we=1 and ready=1; writes with ready=0 SHALL be dropped.
REQ-018 The FSM SHALL have states IDLE, RD, WR_A, WR_B and DONE.
REQ-019 In IDLE with start=1, the block SHALL latch address_A, address_B and op and go to RD; start in any other state SHALL be ignored.
REQ-020 RD SHALL latch tmp_a=mem[A] and tmp_b=mem[B]; it SHALL go to WR_A when op=0, or to WR_B when op=1.
REQ-021 WR_A SHALL write tmp_b to A and go to WR_B.
REQ-022 WR_B SHALL write tmp_a to B and go to DONE.
REQ-023 DONE SHALL assert done and return to IDLE.
REQ-024 Swap latency SHALL be done high 4 cycles after the start-accept edge; copy latency SHALL be 3 cycles.
REQ-025 When we and start are accepted on the same edge, the external write SHALL land first, and RD SHALL see the written value.
REQ-026 With A==B, the operation SHALL run its full length and leave contents unchanged.
REQ-027 Address inputs SHALL be don't-care after the start-accept edge; only the latched copies SHALL be used.

Reset
REQ-028 Reset SHALL force state IDLE, ready=1, done=0, and clear tmp_a and tmp_b to 0.
REQ-029 Reset mid-operation SHALL abort; writes already committed SHALL remain (absent REQ-031), and no done pulse SHALL occur.

Configuration
REQ-030 Macro SWAP_XCHG_CLEAR_EN SHALL select reset-clear of storage.
REQ-031 With SWAP_XCHG_CLEAR_EN defined, reset SHALL clear every storage word to 0.
REQ-032 Without SWAP_XCHG_CLEAR_EN, storage SHALL be untouched by reset.

Structure
REQ-033 Package swap_xchg_pkg SHALL hold the FSM state encoding (3-bit), the op encodings OP_SWAP=0 and OP_COPY=1, and the default widths.
REQ-034 Sub-module swap_xchg_mem SHALL provide the storage array: one synchronous write port, two asynchronous read ports for A/B, and one asynchronous read port for address_r.
REQ-035 The top level SHALL contain the FSM, the temp registers and the write-port mux (external vs. FSM).

Verification
REQ-036 Fill: write mem[i]=i for i=20..29, then read address_r=20..29 -> data_r=20..29.
REQ-037 Swap: start, op=0, A=22, B=28 -> ready low 4 cycles, done pulses once, mem[22]=28, mem[28]=22.
REQ-038 Copy: start, op=1, A=21, B=25 -> done 3 cycles after the accept edge, mem[25]=21, mem[21]=21.
REQ-039 Blocking: hold start=1 for 3 cycles plus we=1 to address 24 while busy -> only one swap occurs, mem[24] unchanged, a repeated swap restores the original values.
REQ-040 Reset on the WR_B edge of a swap of 22/28 -> mem[22]=28 and mem[28]=28 without the macro (both 0 with it), IDLE next cycle, no done pulse.
REQ-041 A==B: swap A=B=23 -> done after 4 cycles, mem[23]=23.
